// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transfer scheduler.
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   localparam logic [1:0] TR_EN_ON  = 2'b01;
   localparam logic [1:0] TR_EN_OFF = 2'b00;
   localparam int         DEF_DEPTH = 8;

   typedef struct packed {
      logic [7:0] comp;
      logic       cpol;
      logic       cpha;
      logic       msb_lsb;
   } cfg_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock show-ahead FIFO; rd_dat shows the head whenever !empty.
// Latency: a write is visible on rd_dat one cycle later.
// Backpressure: writes when full and reads when empty are ignored.
module spi_sync_fifo
   import spi_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          wr,
   input  logic [DW-1:0] wr_dat,
   input  logic          rd,
   output logic [DW-1:0] rd_dat,
   output logic          full,
   output logic          empty
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          wr_ok;
   logic          rd_ok;

   assign full   = (count == FULL_CNT);
   assign empty  = (count == '0);
   assign wr_ok  = wr & ~full;
   assign rd_ok  = rd & ~empty;
   assign rd_dat = mem[rd_ptr];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_ok) begin
            mem[wr_ptr] <= wr_dat;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/spi_fifo_ctrl.sv
// Buffers TX bytes, runs one req/ack core transfer per byte, stores each received byte in RX.
// Latency: byte written into an empty TX with FSM idle raises m_tx_req one cycle later.
// Backpressure: no launch while RX is full; enable=0 aborts the in-flight byte without an RX push.
module spi_fifo_ctrl
   import spi_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = 3
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       enable,
   input  logic [7:0] cfg_comp,
   input  logic       cfg_cpol,
   input  logic       cfg_cpha,
   input  logic       cfg_msb_lsb,
   input  logic       tx_wr,
   input  logic [7:0] tx_wdata,
   output logic       tx_full,
   output logic       tx_empty,
   input  logic       rx_rd,
   output logic [7:0] rx_rdata,
   output logic       rx_empty,
   output logic       rx_full,
   output logic       busy,
   output logic       xfer_done,
   output logic [1:0] m_tr_en,
   output logic [7:0] m_comp,
   output logic       m_cpol,
   output logic       m_cpha,
   output logic       m_msb_lsb,
   output logic [7:0] m_tx_data,
   output logic       m_tx_req,
   input  logic       m_tx_req_ack,
   input  logic [7:0] m_rx_data
);

   state_t     state;
   cfg_t       cfg_q;
   logic [7:0] tx_head_dat;
   logic       launch;
   logic       rx_push_vld;

   assign launch      = enable & (state == ST_IDLE) & ~tx_empty & ~rx_full;
   assign rx_push_vld = enable & (state == ST_REQ) & m_tx_req_ack;
   assign busy        = (state != ST_IDLE);

   assign m_comp    = cfg_q.comp;
   assign m_cpol    = cfg_q.cpol;
   assign m_cpha    = cfg_q.cpha;
   assign m_msb_lsb = cfg_q.msb_lsb;

   spi_sync_fifo #(.DW(8), .DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
      .clk    (clk),
      .resetn (resetn),
      .wr     (tx_wr),
      .wr_dat (tx_wdata),
      .rd     (launch),
      .rd_dat (tx_head_dat),
      .full   (tx_full),
      .empty  (tx_empty)
   );

   spi_sync_fifo #(.DW(8), .DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
      .clk    (clk),
      .resetn (resetn),
      .wr     (rx_push_vld),
      .wr_dat (m_rx_data),
      .rd     (rx_rd),
      .rd_dat (rx_rdata),
      .full   (rx_full),
      .empty  (rx_empty)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         cfg_q     <= '0;
         m_tx_data <= '0;
         m_tx_req  <= 1'b0;
         m_tr_en   <= TR_EN_OFF;
         xfer_done <= 1'b0;
      end else begin
         m_tr_en   <= enable ? TR_EN_ON : TR_EN_OFF;
         xfer_done <= 1'b0;
         // Abort takes priority over any ack arriving on the same edge.
         if (!enable) begin
            state    <= ST_IDLE;
            m_tx_req <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: if (launch) begin
                  m_tx_data     <= tx_head_dat;
                  cfg_q.comp    <= cfg_comp;
                  cfg_q.cpol    <= cfg_cpol;
                  cfg_q.cpha    <= cfg_cpha;
                  cfg_q.msb_lsb <= cfg_msb_lsb;
                  m_tx_req      <= 1'b1;
                  state         <= ST_REQ;
               end
               ST_REQ: if (m_tx_req_ack) begin
                  xfer_done <= 1'b1;
                  m_tx_req  <= 1'b0;
                  state     <= ST_DROP;
               end
               ST_DROP: if (!m_tx_req_ack) state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_fifo_ctrl.sv
// Bench for spi_fifo_ctrl: behavioural SPI core plus an RX scoreboard checked on every RX pop.
module tb_spi_fifo_ctrl;

   logic       clk = 1'b0;
   logic       resetn;
   logic       enable;
   logic [7:0] cfg_comp;
   logic       cfg_cpol, cfg_cpha, cfg_msb_lsb;
   logic       tx_wr;
   logic [7:0] tx_wdata;
   logic       tx_full, tx_empty;
   logic       rx_rd;
   logic [7:0] rx_rdata;
   logic       rx_empty, rx_full;
   logic       busy, xfer_done;
   logic [1:0] m_tr_en;
   logic [7:0] m_comp;
   logic       m_cpol, m_cpha, m_msb_lsb;
   logic [7:0] m_tx_data;
   logic       m_tx_req;
   logic       m_tx_req_ack;
   logic [7:0] m_rx_data;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         done_cnt = 0;
   logic [7:0] exp_q[$];
   logic [7:0] core_xor = 8'h00;
   int         core_cnt;

   always #5 clk = ~clk;

   spi_fifo_ctrl #(.DEPTH(8), .AW(3)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .enable       (enable),
      .cfg_comp     (cfg_comp),
      .cfg_cpol     (cfg_cpol),
      .cfg_cpha     (cfg_cpha),
      .cfg_msb_lsb  (cfg_msb_lsb),
      .tx_wr        (tx_wr),
      .tx_wdata     (tx_wdata),
      .tx_full      (tx_full),
      .tx_empty     (tx_empty),
      .rx_rd        (rx_rd),
      .rx_rdata     (rx_rdata),
      .rx_empty     (rx_empty),
      .rx_full      (rx_full),
      .busy         (busy),
      .xfer_done    (xfer_done),
      .m_tr_en      (m_tr_en),
      .m_comp       (m_comp),
      .m_cpol       (m_cpol),
      .m_cpha       (m_cpha),
      .m_msb_lsb    (m_msb_lsb),
      .m_tx_data    (m_tx_data),
      .m_tx_req     (m_tx_req),
      .m_tx_req_ack (m_tx_req_ack),
      .m_rx_data    (m_rx_data)
   );

   // Core model: ack 20 cycles after req, drop ack one cycle after req falls, held idle while disabled.
   always @(posedge clk) begin
      if (!resetn || m_tr_en != 2'b01) begin
         m_tx_req_ack <= 1'b0;
         m_rx_data    <= 8'h00;
         core_cnt     <= 0;
      end else if (m_tx_req && !m_tx_req_ack) begin
         if (core_cnt == 19) begin
            m_tx_req_ack <= 1'b1;
            m_rx_data    <= m_tx_data ^ core_xor;
            core_cnt     <= 0;
         end else begin
            core_cnt <= core_cnt + 1;
         end
      end else if (!m_tx_req && m_tx_req_ack) begin
         m_tx_req_ack <= 1'b0;
      end
   end

   // Monitor: compare every popped RX byte against the scoreboard and count xfer_done pulses.
   always @(negedge clk) begin
      if (resetn && xfer_done) done_cnt++;
      if (resetn && rx_rd && !rx_empty) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rx_unexpected: got %02h, none expected", rx_rdata);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (rx_rdata !== e) begin
               n_fail++;
               $display("FAIL rx_data: got %02h, expected %02h", rx_rdata, e);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      tx_wr = 1'b1; tx_wdata = b;
      tick();
      tx_wr = 1'b0;
   endtask

   task automatic pop_rx(input int n);
      rx_rd = 1'b1;
      tick(n);
      rx_rd = 1'b0;
   endtask

   task automatic wait_done(input string name, input int target, input int budget);
      int k = 0;
      while (done_cnt < target && k < budget) begin tick(); k++; end
      check(name, done_cnt, target);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k = 0;
      while ((busy || !tx_empty) && k < budget) begin tick(); k++; end
      check(name, {busy, tx_empty}, 2'b01);
   endtask

   initial begin
      int base;
      resetn = 1'b0; enable = 1'b0; tx_wr = 1'b0; tx_wdata = 8'h00; rx_rd = 1'b0;
      cfg_comp = 8'h10; cfg_cpol = 1'b0; cfg_cpha = 1'b1; cfg_msb_lsb = 1'b1;
      tick(3);
      check("reset_flags", {tx_full, tx_empty, rx_full, rx_empty, busy, xfer_done, m_tx_req}, 7'b0101000);
      check("reset_core", {m_tr_en, m_tx_data, m_comp, m_cpol, m_cpha, m_msb_lsb}, 21'h0);
      resetn = 1'b1; enable = 1'b1;
      tick();
      check("tr_en_on", m_tr_en, 2'b01);

      // Single byte with a fixed core reply
      core_xor = 8'hA5 ^ 8'h3C;
      exp_q.push_back(8'h3C);
      push(8'hA5);
      check("lat_no_req_yet", {m_tx_req, tx_empty}, 2'b00);
      tick();
      check("lat_req", {m_tx_req, busy, tx_empty}, 3'b111);
      check("lat_tx_data", m_tx_data, 8'hA5);
      wait_done("single_done", 1, 40);
      check("single_rx_ready", rx_empty, 1'b0);
      pop_rx(1);
      wait_idle("single_idle", 10);
      check("single_rx_empty", rx_empty, 1'b1);

      // Burst into a held TX FIFO, ninth write dropped, echoed back in order
      core_xor = 8'h00;
      enable = 1'b0;
      tick();
      tx_wr = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tx_wdata = 8'(i); exp_q.push_back(8'(i));
         tick();
      end
      check("burst_full", tx_full, 1'b1);
      tx_wdata = 8'h09;
      tick();
      tx_wr = 1'b0;
      check("burst_still_full", tx_full, 1'b1);
      enable = 1'b1;
      base = done_cnt;
      wait_done("burst_done", base + 8, 400);
      tick(3);
      check("burst_rx_full", {rx_full, tx_empty, busy}, 3'b110);

      // RX backpressure holds the next launch
      exp_q.push_back(8'h55);
      push(8'h55);
      tick(30);
      check("bp_no_launch", {m_tx_req, busy, tx_empty}, 3'b000);
      pop_rx(1);
      check("bp_rx_not_full", {rx_full, m_tx_req}, 2'b00);
      tick();
      check("bp_launch", {m_tx_req, m_tx_data}, {1'b1, 8'h55});
      pop_rx(7);
      wait_done("bp_done", base + 9, 40);
      pop_rx(1);
      wait_idle("bp_idle", 10);
      check("bp_rx_drained", rx_empty, 1'b1);

      // Abort mid-transfer; push coincides with the launch pop
      base = done_cnt;
      push(8'hA1);
      exp_q.push_back(8'hB2);
      push(8'hB2);
      check("pushpop_count", {tx_empty, m_tx_req, m_tx_data}, {1'b0, 1'b1, 8'hA1});
      tick(5);
      enable = 1'b0;
      tick();
      check("abort_outputs", {m_tx_req, m_tr_en, busy}, 4'b0000);
      tick(25);
      check("abort_no_push", {rx_empty, tx_empty}, 2'b10);
      check("abort_no_done", done_cnt, base);
      enable = 1'b1;
      tick();
      check("resume_launch", {m_tx_req, m_tr_en, m_tx_data}, {1'b1, 2'b01, 8'hB2});
      wait_done("resume_done", base + 1, 40);
      pop_rx(1);
      wait_idle("resume_idle", 10);

      // Config latched only at launch
      base = done_cnt;
      exp_q.push_back(8'hC3);
      push(8'hC3);
      tick();
      check("cfg_first", {m_cpol, m_comp}, {1'b0, 8'h10});
      cfg_cpol = 1'b1; cfg_comp = 8'h22;
      tick(5);
      check("cfg_held", {m_cpol, m_comp, m_cpha, m_msb_lsb}, {1'b0, 8'h10, 1'b1, 1'b1});
      exp_q.push_back(8'hD4);
      push(8'hD4);
      wait_done("cfg_done", base + 2, 80);
      check("cfg_next", {m_cpol, m_comp, m_tx_data}, {1'b1, 8'h22, 8'hD4});
      pop_rx(2);
      wait_idle("cfg_idle", 10);

      // Reset in the middle of a transfer
      base = done_cnt;
      push(8'hE5);
      tick(3);
      check("pre_reset_busy", {busy, m_tx_req}, 2'b11);
      resetn = 1'b0;
      #1;
      check("mid_reset_flags", {tx_empty, rx_empty, busy, m_tx_req, m_tr_en, m_tx_data}, {4'b1100, 2'b00, 8'h00});
      tick(3);
      resetn = 1'b1;
      tick();
      check("post_reset", {busy, tx_empty, rx_empty, m_tr_en}, 5'b01101);
      tick(30);
      check("post_reset_quiet", {m_tx_req, done_cnt == base}, 2'b01);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
